// File: rtl/f_node_loader.sv
// F_node weight loader: collects one frame of 16 weights over a valid/ready
// handshake into a shadow buffer, then publishes the whole frame to the
// write_in_k outputs in one step and strobes write_enable to the weight store.
module f_node_loader #(
    parameter int WEIGHT_W = 5,
    parameter int NUM_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic                w_valid,
    input  logic [WEIGHT_W-1:0] w_data,
    output logic                w_ready,
    output logic                write_enable,
    output logic [WEIGHT_W-1:0] write_in_1,
    output logic [WEIGHT_W-1:0] write_in_2,
    output logic [WEIGHT_W-1:0] write_in_3,
    output logic [WEIGHT_W-1:0] write_in_4,
    output logic [WEIGHT_W-1:0] write_in_5,
    output logic [WEIGHT_W-1:0] write_in_6,
    output logic [WEIGHT_W-1:0] write_in_7,
    output logic [WEIGHT_W-1:0] write_in_8,
    output logic [WEIGHT_W-1:0] write_in_9,
    output logic [WEIGHT_W-1:0] write_in_10,
    output logic [WEIGHT_W-1:0] write_in_11,
    output logic [WEIGHT_W-1:0] write_in_12,
    output logic [WEIGHT_W-1:0] write_in_13,
    output logic [WEIGHT_W-1:0] write_in_14,
    output logic [WEIGHT_W-1:0] write_in_15,
    output logic [WEIGHT_W-1:0] write_in_16,
    output logic                busy,
    output logic                done,
    output logic [4:0]          count
);

    // Only a 16-weight frame is supported; the count of the final weight is
    // derived from NUM_W so the comparison stays in one place.
    localparam logic [4:0] LAST_IDX = 5'(NUM_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [WEIGHT_W-1:0] shadow    [NUM_W];
    logic [WEIGHT_W-1:0] committed [NUM_W];

    logic handshake;
    logic last_word;

    // An abort in LOAD wins over a same-edge handshake, so the handshake is
    // qualified with !abort before it can touch count or the shadow buffer.
    assign handshake = (state == LOAD) && w_valid && !abort;
    assign last_word = handshake && (count == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; COMMIT and DONE are single-cycle and ignore controls
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (last_word) begin
                    next_state = COMMIT;
                end
            end
            COMMIT: begin
                next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode purely from state
    always_comb begin
        w_ready      = (state == LOAD);
        write_enable = (state == COMMIT);
        done         = (state == DONE);
        busy         = (state != IDLE);
    end

    // Accepted-weight counter: cleared on frame start or abort, otherwise it
    // holds its final value of 16 through COMMIT, DONE and IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if ((state == IDLE) && start) begin
            count <= '0;
        end else if ((state == LOAD) && abort) begin
            count <= '0;
        end else if (handshake) begin
            count <= count + 5'd1;
        end
    end

    // Shadow buffer: each accepted weight lands in the slot after the
    // previously accepted one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_W; i++) begin
                shadow[i] <= '0;
            end
        end else if (handshake) begin
            shadow[count[3:0]] <= w_data;
        end
    end

    // Published frame: updated only on the edge that accepts the last
    // weight, with that weight taken straight from the input bus
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_W; i++) begin
                committed[i] <= '0;
            end
        end else if (last_word) begin
            for (int i = 0; i < NUM_W - 1; i++) begin
                committed[i] <= shadow[i];
            end
            committed[NUM_W-1] <= w_data;
        end
    end

    assign write_in_1  = committed[0];
    assign write_in_2  = committed[1];
    assign write_in_3  = committed[2];
    assign write_in_4  = committed[3];
    assign write_in_5  = committed[4];
    assign write_in_6  = committed[5];
    assign write_in_7  = committed[6];
    assign write_in_8  = committed[7];
    assign write_in_9  = committed[8];
    assign write_in_10 = committed[9];
    assign write_in_11 = committed[10];
    assign write_in_12 = committed[11];
    assign write_in_13 = committed[12];
    assign write_in_14 = committed[13];
    assign write_in_15 = committed[14];
    assign write_in_16 = committed[15];

endmodule

// File: tb/tb_f_node_loader.sv
// Self-checking bench for f_node_loader: a table of directed vectors for the
// back-to-back load, hand-written corner sequences, and a randomized run
// compared against a frame-level behavioural model.
module tb_f_node_loader;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic       w_valid;
    logic [4:0] w_data;
    logic       w_ready;
    logic       write_enable;
    logic       busy;
    logic       done;
    logic [4:0] count;
    logic [4:0] wi [16];

    int compared;
    int mismatched;
    int we_pulses;
    int done_pulses;

    typedef struct {
        logic       start;
        logic       abort;
        logic       w_valid;
        logic [4:0] w_data;
        logic       exp_ready;
        logic       exp_we;
        logic       exp_done;
        logic       exp_busy;
        logic [4:0] exp_count;
    } vec_t;

    vec_t vecs [20];

    // Behavioural model state: the frame is a queue of accepted words
    logic [4:0] m_frame [$];
    logic [4:0] m_committed [16];
    bit         m_loading;
    int         m_after_full;
    int         m_count;

    f_node_loader #(.WEIGHT_W(5), .NUM_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .w_valid      (w_valid),
        .w_data       (w_data),
        .w_ready      (w_ready),
        .write_enable (write_enable),
        .write_in_1   (wi[0]),
        .write_in_2   (wi[1]),
        .write_in_3   (wi[2]),
        .write_in_4   (wi[3]),
        .write_in_5   (wi[4]),
        .write_in_6   (wi[5]),
        .write_in_7   (wi[6]),
        .write_in_8   (wi[7]),
        .write_in_9   (wi[8]),
        .write_in_10  (wi[9]),
        .write_in_11  (wi[10]),
        .write_in_12  (wi[11]),
        .write_in_13  (wi[12]),
        .write_in_14  (wi[13]),
        .write_in_15  (wi[14]),
        .write_in_16  (wi[15]),
        .busy         (busy),
        .done         (done),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass, sample on the
    // following falling edge and tally strobes
    task automatic step(input logic s, input logic a, input logic v, input logic [4:0] d);
        start   = s;
        abort   = a;
        w_valid = v;
        w_data  = d;
        @(negedge clk);
        if (write_enable) we_pulses++;
        if (done) done_pulses++;
    endtask

    task automatic check_frame(input string name, input int base, input int all_zero);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("%s write_in_%0d", name, k + 1), int'(wi[k]),
                  (all_zero != 0) ? 0 : base + k + 1);
        end
    endtask

    task automatic check_idle_outputs(input string name, input int exp_count);
        check({name, " w_ready"}, int'(w_ready), 0);
        check({name, " write_enable"}, int'(write_enable), 0);
        check({name, " done"}, int'(done), 0);
        check({name, " busy"}, int'(busy), 0);
        check({name, " count"}, int'(count), exp_count);
    endtask

    // Frame-level reference: a frame starts, collects words until sixteen
    // are held, then spends one cycle writing and one cycle announcing
    task automatic model_step(input logic s, input logic a, input logic v, input logic [4:0] d);
        if (m_after_full == 1) begin
            m_after_full = 2;
        end else if (m_after_full == 2) begin
            m_after_full = 0;
        end else if (m_loading) begin
            if (a) begin
                m_loading = 0;
                m_frame.delete();
                m_count = 0;
            end else if (v) begin
                m_frame.push_back(d);
                m_count = m_frame.size();
                if (m_frame.size() == 16) begin
                    for (int k = 0; k < 16; k++) m_committed[k] = m_frame[k];
                    m_frame.delete();
                    m_loading    = 0;
                    m_after_full = 1;
                end
            end
        end else if (s) begin
            m_loading = 1;
            m_frame.delete();
            m_count = 0;
        end
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        we_pulses   = 0;
        done_pulses = 0;

        // Directed back-to-back frame: start, then words 1..16 on consecutive edges
        vecs[0] = '{1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0};
        for (int k = 1; k <= 16; k++) begin
            if (k < 16)
                vecs[k] = '{1'b0, 1'b0, 1'b1, 5'(k), 1'b1, 1'b0, 1'b0, 1'b1, 5'(k)};
            else
                vecs[k] = '{1'b0, 1'b0, 1'b1, 5'(k), 1'b0, 1'b1, 1'b0, 1'b1, 5'(k)};
        end
        vecs[17] = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd16};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16};

        // Reset state, checked before any clock edge
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        w_valid = 1'b0;
        w_data  = '0;
        #2;
        check_idle_outputs("reset", 0);
        check_frame("reset", 0, 1);
        @(negedge clk);
        reset_n = 1'b1;

        // Stays idle after release until start is seen, even with valid data
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 5'd9);
            check_idle_outputs("post-reset idle", 0);
        end

        // Table-driven back-to-back load
        we_pulses   = 0;
        done_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(vecs[i].start, vecs[i].abort, vecs[i].w_valid, vecs[i].w_data);
            check($sformatf("b2b[%0d] w_ready", i), int'(w_ready), int'(vecs[i].exp_ready));
            check($sformatf("b2b[%0d] write_enable", i), int'(write_enable), int'(vecs[i].exp_we));
            check($sformatf("b2b[%0d] done", i), int'(done), int'(vecs[i].exp_done));
            check($sformatf("b2b[%0d] busy", i), int'(busy), int'(vecs[i].exp_busy));
            check($sformatf("b2b[%0d] count", i), int'(count), int'(vecs[i].exp_count));
            check($sformatf("b2b[%0d] we&done", i), int'(write_enable & done), 0);
        end
        check_frame("b2b", 0, 0);

        // Abort after seven words of 5'h1F with a same-edge handshake
        we_pulses = 0;
        step(1'b1, 1'b0, 1'b0, 5'd0);
        for (int k = 1; k <= 7; k++) step(1'b0, 1'b0, 1'b1, 5'h1F);
        check("abort pre count", int'(count), 7);
        step(1'b0, 1'b1, 1'b1, 5'h1F);
        check_idle_outputs("abort", 0);
        step(1'b0, 1'b0, 1'b0, 5'd0);
        check_idle_outputs("abort after", 0);
        check("abort we pulses", we_pulses, 0);
        check_frame("abort", 0, 0);

        // Randomized traffic against the frame-level model
        m_loading    = 0;
        m_after_full = 0;
        m_count      = 0;
        m_frame.delete();
        for (int k = 0; k < 16; k++) m_committed[k] = 5'(k + 1);
        for (int c = 0; c < 3000; c++) begin
            logic s, a, v;
            logic [4:0] d;
            s = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 9) < 7);
            d = 5'($urandom);
            model_step(s, a, v, d);
            step(s, a, v, d);
            check("rnd w_ready", int'(w_ready), int'(m_loading));
            check("rnd write_enable", int'(write_enable), int'(m_after_full == 1));
            check("rnd done", int'(done), int'(m_after_full == 2));
            check("rnd busy", int'(busy), int'(m_loading || (m_after_full != 0)));
            check("rnd count", int'(count), m_count);
            for (int k = 0; k < 16; k++)
                check($sformatf("rnd write_in_%0d", k + 1), int'(wi[k]), int'(m_committed[k]));
        end

        // Return to idle: abort ends a load, COMMIT/DONE drain by themselves
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 5'd0);
        check("drain busy", int'(busy), 0);

        // Stalled load: valid toggles, count moves only on handshakes
        we_pulses   = 0;
        done_pulses = 0;
        step(1'b1, 1'b0, 1'b0, 5'd0);
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 1'b0, 1'b1, 5'(k));
            check($sformatf("stall count after hs %0d", k), int'(count), k);
            if (k < 16) begin
                step(1'b0, 1'b0, 1'b0, ~5'(k));
                check($sformatf("stall count hold %0d", k), int'(count), k);
                check($sformatf("stall ready hold %0d", k), int'(w_ready), 1);
            end
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 5'd0);
        check("stall we pulses", we_pulses, 1);
        check("stall done pulses", done_pulses, 1);
        check("stall busy end", int'(busy), 0);
        check_frame("stall", 0, 0);

        // Ignored controls: start during LOAD and COMMIT, abort during COMMIT
        we_pulses   = 0;
        done_pulses = 0;
        step(1'b1, 1'b0, 1'b0, 5'd0);
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'b0, 1'b1, 5'(k + 10));
            check($sformatf("ign count %0d", k), int'(count), k);
        end
        check("ign commit we", int'(write_enable), 1);
        step(1'b1, 1'b1, 1'b0, 5'd0);
        check("ign done", int'(done), 1);
        check("ign done count", int'(count), 16);
        step(1'b1, 1'b0, 1'b0, 5'd0);
        check("ign idle busy", int'(busy), 0);
        step(1'b0, 1'b0, 1'b0, 5'd0);
        check("ign we pulses", we_pulses, 1);
        check("ign done pulses", done_pulses, 1);
        check_frame("ign", 10, 0);

        // Asynchronous reset pulse between edges during LOAD at count 10
        we_pulses = 0;
        step(1'b1, 1'b0, 1'b0, 5'd0);
        for (int k = 1; k <= 10; k++) step(1'b0, 1'b0, 1'b1, 5'(k + 3));
        check("rst pre count", int'(count), 10);
        #2 reset_n = 1'b0;
        #1;
        check_idle_outputs("async rst", 0);
        check_frame("async rst", 0, 1);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b1, 5'(i));
            check($sformatf("post rst busy %0d", i), int'(busy), 0);
        end
        check("post rst we pulses", we_pulses, 0);
        check("post rst count", int'(count), 0);
        check_frame("post rst", 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
